// File: rtl/axis_pack_arbiter.sv
// rtl/axis_pack_arbiter.sv - packet-locked round-robin arbiter for sparse AXI-Stream sources
// Feeds one registered sparse output slice, dropping empty non-last beats and tagging each beat with its source.
module axis_pack_arbiter #(
  parameter int N_SRC  = 4,
  parameter int DWIDTH = 32,
  parameter int SRC_W  = $clog2(N_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC*DWIDTH-1:0]   s_tdata,
  input  logic [N_SRC*DWIDTH/8-1:0] s_tkeep,
  input  logic [N_SRC-1:0]          s_tlast,
  input  logic [N_SRC-1:0]          s_tvalid,
  output logic [N_SRC-1:0]          s_tready,
  output logic [DWIDTH-1:0]         m_tdata,
  output logic [DWIDTH/8-1:0]       m_tkeep,
  output logic                      m_tlast,
  output logic [SRC_W-1:0]          m_tid,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      busy
);

  localparam int KW = DWIDTH / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SRC_W-1:0] r_grant;
  logic [SRC_W-1:0] w_grant_nxt;
  logic [SRC_W-1:0] r_rr_ptr;
  logic [SRC_W-1:0] w_rr_ptr_nxt;
  logic [SRC_W-1:0] w_winner;
  logic [SRC_W-1:0] w_grant_inc;
  logic [SRC_W-1:0] w_rr_sel;
  int               w_rr_idx;
  logic             w_any_valid;

  logic [DWIDTH-1:0] w_g_tdata;
  logic [KW-1:0]     w_g_tkeep;
  logic              w_g_tlast;
  logic              w_g_tvalid;

  logic w_slice_ready;
  logic w_accept;
  logic w_forward;

  logic [DWIDTH-1:0] r_m_tdata;
  logic [KW-1:0]     r_m_tkeep;
  logic              r_m_tlast;
  logic [SRC_W-1:0]  r_m_tid;
  logic              r_m_tvalid;

  // Scan from the far end toward rr_ptr so the nearest valid source is the last one written.
  always_comb begin
    w_winner    = r_rr_ptr;
    w_rr_idx    = 0;
    w_rr_sel    = '0;
    w_any_valid = |s_tvalid;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      w_rr_idx = int'(r_rr_ptr) + k;
      if (w_rr_idx >= N_SRC) begin
        w_rr_idx = w_rr_idx - N_SRC;
      end
      w_rr_sel = SRC_W'(w_rr_idx);
      if (s_tvalid[w_rr_sel]) begin
        w_winner = w_rr_sel;
      end
    end
  end

  always_comb begin
    w_g_tdata  = '0;
    w_g_tkeep  = '0;
    w_g_tlast  = 1'b0;
    w_g_tvalid = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant == SRC_W'(i)) begin
        w_g_tdata  = s_tdata[i*DWIDTH +: DWIDTH];
        w_g_tkeep  = s_tkeep[i*KW +: KW];
        w_g_tlast  = s_tlast[i];
        w_g_tvalid = s_tvalid[i];
      end
    end
  end

  assign w_grant_inc   = (r_grant == SRC_W'(N_SRC - 1)) ? '0 : r_grant + 1'b1;
  assign w_slice_ready = ~r_m_tvalid | m_tready;
  assign w_accept      = (r_state == ST_LOCK) & w_g_tvalid & w_slice_ready;
  assign w_forward     = w_accept & ((|w_g_tkeep) | w_g_tlast);

  // Ready never looks at s_tvalid, only at the slice state and downstream ready.
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      s_tready[i] = (r_state == ST_LOCK) && (r_grant == SRC_W'(i)) && w_slice_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = ST_LOCK;
          w_grant_nxt = w_winner;
        end
      end
      ST_LOCK: begin
        if (w_accept && w_g_tlast) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = w_grant_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output slice: load on a forwarded beat, otherwise drain on m_tready and hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
      r_m_tvalid <= 1'b0;
    end else if (w_forward) begin
      r_m_tdata  <= w_g_tdata;
      r_m_tkeep  <= w_g_tkeep;
      r_m_tlast  <= w_g_tlast;
      r_m_tid    <= r_grant;
      r_m_tvalid <= 1'b1;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tdata  = r_m_tdata;
  assign m_tkeep  = r_m_tkeep;
  assign m_tlast  = r_m_tlast;
  assign m_tid    = r_m_tid;
  assign m_tvalid = r_m_tvalid;
  assign busy     = (r_state == ST_LOCK);

endmodule

// File: tb/tb_axis_pack_arbiter.sv
// tb/tb_axis_pack_arbiter.sv - randomized scoreboard bench for axis_pack_arbiter
// Packets are staged per source, ordered by a packet-level round-robin model, and checked beat by beat.
module tb_axis_pack_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [SW-1:0] tid;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N*DW-1:0] s_tdata  = '0;
  logic [N*KW-1:0] s_tkeep  = '0;
  logic [N-1:0]    s_tlast  = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic [SW-1:0]   m_tid;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            busy;

  axis_pack_arbiter #(.N_SRC(N), .DWIDTH(DW), .SRC_W(SW)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  beat_t  src_q[N][$];
  beat_t  stg_q[N][$];
  int     stg_len[N][$];
  int     stg_cnt[N] = '{default: 0};
  exp_t   exp_q[$];
  logic [N-1:0] pres  = '0;
  logic [N-1:0] first = '1;
  int     model_ptr  = 0;
  bit     rand_ready = 1'b0;
  bit     gap_en     = 1'b0;
  logic   ready_val  = 1'b1;
  int     errs   = 0;
  int     checks = 0;

  logic [N-1:0] t1_rdy [6] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
  logic         t1_vld [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic         t1_bsy [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    check(name, 64'(act), 64'(req));
  endtask

  function automatic logic [KW-1:0] rand_keep();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return '1;
    if (r == 1) return '0;
    return KW'($urandom);
  endfunction

  task automatic add_beat(input int s, input logic [KW-1:0] keep, input logic last);
    beat_t b;
    b.data = $urandom;
    b.keep = keep;
    b.last = last;
    stg_q[s].push_back(b);
    stg_cnt[s]++;
    if (last) begin
      stg_len[s].push_back(stg_cnt[s]);
      stg_cnt[s] = 0;
    end
  endtask

  // Packet-level arbitration: every source with staged packets keeps valid high,
  // so each grant goes to the first source at or after the pointer that still has a packet.
  task automatic launch();
    int   w;
    int   len;
    int   idx;
    bit   found;
    beat_t b;
    exp_t  e;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      w = 0;
      for (int k = 0; k < N; k++) begin
        idx = (model_ptr + k) % N;
        if (!found && stg_len[idx].size() > 0) begin
          w = idx;
          found = 1'b1;
        end
      end
      if (found) begin
        len = stg_len[w].pop_front();
        for (int j = 0; j < len; j++) begin
          b = stg_q[w].pop_front();
          src_q[w].push_back(b);
          if (b.keep != '0 || b.last) begin
            e.b   = b;
            e.tid = SW'(w);
            exp_q.push_back(e);
          end
        end
        model_ptr = (w + 1) % N;
      end
    end
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int i = 0; i < N; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check1(name, n < budget, 1'b1);
    @(negedge clk);
  endtask

  initial begin : driver
    logic [N-1:0] acc;
    beat_t b;
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready & {N{~rst}};
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          b = src_q[i].pop_front();
          first[i] = b.last;
          pres[i]  = 1'b0;
        end
        if (!pres[i] && src_q[i].size() > 0 &&
            (!gap_en || first[i] || $urandom_range(0, 3) != 0)) begin
          pres[i] = 1'b1;
        end
        s_tvalid[i] = pres[i];
        if (pres[i]) begin
          s_tdata[i*DW +: DW] = src_q[i][0].data;
          s_tkeep[i*KW +: KW] = src_q[i][0].keep;
          s_tlast[i]          = src_q[i][0].last;
        end else begin
          s_tdata[i*DW +: DW] = $urandom;
          s_tkeep[i*KW +: KW] = KW'($urandom);
          s_tlast[i]          = 1'($urandom);
        end
      end
      m_tready = rand_ready ? ($urandom_range(0, 9) < 7) : ready_val;
    end
  end

  initial begin : monitor
    logic hold;
    exp_t prev;
    exp_t got;
    exp_t e;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        got = {m_tdata, m_tkeep, m_tlast, m_tid};
        if (hold) begin
          check1("hold_valid", m_tvalid, 1'b1);
          check("hold_data", 64'(got), 64'(prev));
        end
        if (m_tvalid && !m_tready) check("stall_s_tready", 64'(s_tready), 64'(0));
        check1("s_tready_onehot0", $onehot0(s_tready), 1'b1);
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_beat: got %0h required none", got);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(got), 64'(e));
          end
        end
        hold = m_tvalid && !m_tready;
        prev = got;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d required 0", pending());
    $fatal(1);
  end

  initial begin : main
    int n;
    int np;
    int len;
    logic [N-1:0] mask;

    repeat (3) @(negedge clk);
    check1("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_slice", 64'({m_tdata, m_tkeep, m_tlast, m_tid}), 64'(0));
    check1("rst_busy", busy, 1'b0);
    check("rst_s_tready", 64'(s_tready), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single source, 3-beat packet, cycle-exact handshake timing.
    add_beat(1, 4'hF, 1'b0);
    add_beat(1, 4'hF, 1'b0);
    add_beat(1, 4'h3, 1'b1);
    launch();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_s_tready", 64'(s_tready), 64'(t1_rdy[k]));
      check1("t1_m_tvalid", m_tvalid, t1_vld[k]);
      check1("t1_busy", busy, t1_bsy[k]);
    end
    wait_done("t1_done", 50);

    // All sources valid with 2-beat packets: one bubble cycle between packets.
    for (int s = 0; s < N; s++) begin
      add_beat(s, 4'hF, 1'b0);
      add_beat(s, 4'hF, 1'b1);
    end
    launch();
    n = 0;
    while (!m_tvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t2_first_out", 64'(n), 64'(3));
    for (int j = 0; j < 11; j++) begin
      check1("t2_pattern", m_tvalid, (j % 3) != 2);
      @(negedge clk);
    end
    wait_done("t2_done", 100);

    // Wrap-around: after src2 the pointer sits at 3, so src0 must win over src1.
    add_beat(2, 4'hF, 1'b1);
    launch();
    wait_done("wrap_a_done", 50);
    add_beat(0, 4'h1, 1'b1);
    add_beat(1, 4'h2, 1'b1);
    launch();
    wait_done("wrap_b_done", 50);

    // Empty non-last beat dropped, empty last beat forwarded.
    rand_ready = 1'b1;
    add_beat(0, 4'hF, 1'b0);
    add_beat(0, 4'h0, 1'b0);
    add_beat(0, 4'h0, 1'b1);
    launch();
    wait_done("drop_done", 100);

    // Five cycles of downstream backpressure in the middle of a packet.
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    for (int j = 0; j < 6; j++) add_beat(1, 4'hF, j == 5);
    launch();
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (src_q[1].size() > 3 && n < 20);
    check1("bp_reached", n < 20, 1'b1);
    ready_val = 1'b0;
    m_tready  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check1("bp_m_tvalid", m_tvalid, 1'b1);
      check("bp_s_tready", 64'(s_tready), 64'(0));
    end
    @(posedge clk);
    #2;
    ready_val = 1'b1;
    m_tready  = 1'b1;
    wait_done("bp_done", 100);

    // Randomized phases with source gaps and random downstream ready.
    rand_ready = 1'b1;
    gap_en     = 1'b1;
    for (int p = 0; p < 12; p++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int s = 0; s < N; s++) begin
        if (mask[s]) begin
          np = $urandom_range(1, 3);
          for (int q = 0; q < np; q++) begin
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) add_beat(s, rand_keep(), j == len - 1);
          end
        end
      end
      launch();
      wait_done("rand_phase_done", 2000);
    end

    // Reset during beat 2 of a src3 packet.
    rand_ready = 1'b0;
    gap_en     = 1'b0;
    ready_val  = 1'b1;
    for (int j = 0; j < 4; j++) add_beat(3, 4'hF, j == 3);
    launch();
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (src_q[3].size() > 3 && n < 20);
    check1("mid_rst_reached", n < 20, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      s_tvalid[i] = 1'b0;
    end
    pres = '0;
    first = '1;
    exp_q.delete();
    model_ptr = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check1("mid_rst_m_tvalid", m_tvalid, 1'b0);
    check("mid_rst_s_tready", 64'(s_tready), 64'(0));
    check1("mid_rst_busy", busy, 1'b0);
    add_beat(3, 4'h7, 1'b1);
    add_beat(1, 4'hC, 1'b1);
    launch();
    wait_done("post_rst_done", 100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
